// File: rtl/axi_arb_pkg.sv
// Shared types and the round-robin selection helper for the AW/W write arbiter.
package axi_arb_pkg;

    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    typedef logic [MAX_IDX_W-1:0] idx_t;

    // First set bit of valid at or after ptr, wrapping at n; returns 0 when none is set.
    function automatic idx_t rr_next(input logic [MAX_REQ-1:0] valid, input idx_t ptr,
                                     input int unsigned n);
        idx_t        sel;
        logic        found;
        int unsigned cand;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = (32'(ptr) + i) % n;
            if (i < n && !found && valid[cand[MAX_IDX_W-1:0]]) begin
                sel   = cand[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axi_order_fifo.sv
// Synchronous FIFO recording AW grant order so W bursts can be routed to the matching requester.
module axi_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop never makes room for a push in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_aw_w_rr_arbiter.sv
// Round-robin AW arbiter with a registered AW output; W bursts follow AW grant order.
module axi_aw_w_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NB_REQ      = 4,
    parameter int AW_WIDTH    = 64,
    parameter int W_WIDTH     = 73,
    parameter int ORDER_DEPTH = 4,
    parameter int IDX_W       = $clog2(NB_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_REQ-1:0]            req_aw_valid_i,
    input  logic [NB_REQ*AW_WIDTH-1:0]   req_aw_data_i,
    output logic [NB_REQ-1:0]            req_aw_ready_o,
    input  logic [NB_REQ-1:0]            req_w_valid_i,
    input  logic [NB_REQ*W_WIDTH-1:0]    req_w_data_i,
    input  logic [NB_REQ-1:0]            req_w_last_i,
    output logic [NB_REQ-1:0]            req_w_ready_o,
    output logic                         out_aw_valid_o,
    output logic [AW_WIDTH-1:0]          out_aw_data_o,
    output logic [IDX_W-1:0]             out_aw_idx_o,
    input  logic                         out_aw_ready_i,
    output logic                         out_w_valid_o,
    output logic [W_WIDTH-1:0]           out_w_data_o,
    output logic                         out_w_last_o,
    input  logic                         out_w_ready_i
);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   w_head;
    logic [MAX_REQ-1:0] aw_valid_ext;
    logic               aw_loadable;
    logic               grant;
    logic               fifo_full;
    logic               fifo_empty;
    logic               w_pop;

    assign aw_valid_ext = MAX_REQ'(req_aw_valid_i);
    assign winner       = IDX_W'(rr_next(aw_valid_ext, MAX_IDX_W'(rr_ptr), NB_REQ));
    assign aw_loadable  = !out_aw_valid_o || out_aw_ready_i;
    assign grant        = !rst && aw_loadable && !fifo_full && (|req_aw_valid_i);

    always_comb begin
        req_aw_ready_o = '0;
        if (grant) begin
            req_aw_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_aw_valid_o <= 1'b0;
            out_aw_data_o  <= '0;
            out_aw_idx_o   <= '0;
            rr_ptr         <= '0;
        end else if (grant) begin
            out_aw_valid_o <= 1'b1;
            out_aw_data_o  <= req_aw_data_i[winner*AW_WIDTH +: AW_WIDTH];
            out_aw_idx_o   <= winner;
            rr_ptr         <= (winner == IDX_W'(NB_REQ-1)) ? '0 : winner + 1'b1;
        end else if (out_aw_ready_i) begin
            out_aw_valid_o <= 1'b0;
        end
    end

    axi_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant),
        .pop     (w_pop),
        .wr_data (winner),
        .rd_data (w_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // W is gated off during reset so stale order entries never reach the master.
    always_comb begin
        out_w_valid_o = 1'b0;
        out_w_data_o  = '0;
        out_w_last_o  = 1'b0;
        req_w_ready_o = '0;
        if (!rst && !fifo_empty) begin
            out_w_valid_o         = req_w_valid_i[w_head];
            out_w_data_o          = req_w_data_i[w_head*W_WIDTH +: W_WIDTH];
            out_w_last_o          = req_w_last_i[w_head];
            req_w_ready_o[w_head] = out_w_ready_i;
        end
    end

    assign w_pop = out_w_valid_o && out_w_ready_i && out_w_last_o;

endmodule
